// File: rtl/ramb16_s4_s36_fifo_pkg.sv
// rtl/ramb16_s4_s36_fifo_pkg.sv - shared constants, pointer types and helpers for the nibble-in/word-out FIFO
package ramb16_s4_s36_fifo_pkg;

  localparam int NIB_PER_WORD = 8;
  localparam int DEPTH_WORDS  = 512;
  localparam int ADDRA_W      = 12;
  localparam int ADDRB_W      = 9;
  localparam int LEVEL_W      = 10;

  // Nibble pointer carries one extra wrap bit above the port A address
  localparam int WP_W      = ADDRA_W + 1;
  localparam int NIB_SHIFT = $clog2(NIB_PER_WORD);

  typedef logic [WP_W-1:0]    nib_ptr_t;
  typedef logic [LEVEL_W-1:0] word_ptr_t;

  // Committed-word pointer: drops the nibble-within-word bits
  function automatic word_ptr_t word_of(input nib_ptr_t p);
    return p[WP_W-1:NIB_SHIFT];
  endfunction

  // Occupancy between two word pointers, modulo 1024
  function automatic word_ptr_t ptr_diff(input word_ptr_t a, input word_ptr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/ramb16_s4_s36_fifo_rdq.sv
// rtl/ramb16_s4_s36_fifo_rdq.sv - two-entry registered output queue (head plus skid) for RAM read words
module ramb16_s4_s36_fifo_rdq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic [1:0]  count_o
);

  logic [31:0] head_q, head_d;
  logic [31:0] skid_q, skid_d;
  logic [1:0]  cnt_q, cnt_d;

  // Head always holds the oldest word so the output is straight from a flop
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      skid_d = '0;
      cnt_d  = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = push_data_i;
          end else begin
            skid_d = push_data_i;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = skid_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = skid_q;
            skid_d = push_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Queue state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ramb16_s4_s36_fifo_ctrl.sv
// rtl/ramb16_s4_s36_fifo_ctrl.sv - FIFO controller driving a RAMB16_S4_S36: nibbles in on port A, words out on port B
module ramb16_s4_s36_fifo_ctrl
  import ramb16_s4_s36_fifo_pkg::*;
#(
  parameter int AFULL_WORDS = 480
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [3:0]         wr_data_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [31:0]        rd_data_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               afull_o,
  output logic [ADDRA_W-1:0] ram_addra_o,
  output logic [3:0]         ram_dia_o,
  output logic               ram_ena_o,
  output logic               ram_wea_o,
  output logic [ADDRB_W-1:0] ram_addrb_o,
  output logic               ram_enb_o,
  input  logic [31:0]        ram_dob_i
);

  nib_ptr_t  wp_q, wp_d;
  word_ptr_t pp_q, pp_d;
  word_ptr_t ip_q, ip_d;
  word_ptr_t ww_q, ww_d;
  word_ptr_t level_q, level_d;
  logic      full_q, full_d;
  logic      afull_q, afull_d;
  logic      empty_q, empty_d;
  logic      inflight_q, inflight_d;

  logic        wr_fire;
  logic        pop;
  logic        issue;
  logic        capture;
  logic [1:0]  q_count;
  logic [2:0]  q_busy;
  logic        q_valid;
  logic [31:0] q_data;

  // Port A: every accepted nibble goes straight into the RAM at the write pointer
  always_comb begin
    wr_ready_o  = !full_q && !flush_i;
    wr_fire     = wr_valid_i && wr_ready_o;
    ram_ena_o   = wr_fire;
    ram_wea_o   = wr_fire;
    ram_addra_o = wp_q[ADDRA_W-1:0];
    ram_dia_o   = wr_data_i;
  end

  // Port B: issue a read when a committed word is unread and the queue has room,
  // counting a same-cycle pop as freed space so the output can stream every cycle
  always_comb begin
    ww_q        = word_of(wp_q);
    pop         = q_valid && rd_ready_i && !flush_i;
    q_busy      = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = !flush_i && (ip_q != ww_q) && (q_busy < 3'd2);
    capture     = inflight_q && !flush_i;
    ram_enb_o   = issue;
    ram_addrb_o = ip_q[ADDRB_W-1:0];
  end

  // Pointer and status next-state; flags derive from the next level so they stay in step with it
  always_comb begin
    if (flush_i) begin
      wp_d       = '0;
      pp_d       = '0;
      ip_d       = '0;
      inflight_d = 1'b0;
    end else begin
      wp_d       = wp_q + nib_ptr_t'(wr_fire);
      pp_d       = pp_q + word_ptr_t'(pop);
      ip_d       = ip_q + word_ptr_t'(issue);
      inflight_d = issue;
    end
    ww_d    = word_of(wp_d);
    level_d = ptr_diff(ww_d, pp_d);
    full_d  = (level_d == word_ptr_t'(DEPTH_WORDS));
    afull_d = (level_d >= word_ptr_t'(AFULL_WORDS));
    empty_d = (level_d == '0);
  end

  // Pointer, in-flight and status registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q       <= '0;
      pp_q       <= '0;
      ip_q       <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wp_q       <= wp_d;
      pp_q       <= pp_d;
      ip_q       <= ip_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      empty_q    <= empty_d;
    end
  end

  ramb16_s4_s36_fifo_rdq u_rdq (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .push_i      (capture),
    .push_data_i (ram_dob_i),
    .pop_i       (pop),
    .valid_o     (q_valid),
    .data_o      (q_data),
    .count_o     (q_count)
  );

  assign rd_valid_o = q_valid;
  assign rd_data_o  = q_data;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign afull_o    = afull_q;
  assign empty_o    = empty_q;

endmodule

// File: tb/tb_ramb16_s4_s36_fifo_ctrl.sv
// tb/tb_ramb16_s4_s36_fifo_ctrl.sv - directed and scoreboard bench for the nibble-to-word FIFO controller
module tb_ramb16_s4_s36_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [9:0]  level;
  logic        full, empty, afull;
  logic [11:0] ram_addra;
  logic [3:0]  ram_dia;
  logic        ram_ena, ram_wea;
  logic [8:0]  ram_addrb;
  logic        ram_enb;
  logic [31:0] ram_dob;

  int checks = 0;
  int failures = 0;
  int enb_cnt = 0;

  always #5 clk = ~clk;

  ramb16_s4_s36_fifo_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .afull_o     (afull),
    .ram_addra_o (ram_addra),
    .ram_dia_o   (ram_dia),
    .ram_ena_o   (ram_ena),
    .ram_wea_o   (ram_wea),
    .ram_addrb_o (ram_addrb),
    .ram_enb_o   (ram_enb),
    .ram_dob_i   (ram_dob)
  );

  // Behavioural RAMB16_S4_S36: 4096 nibbles, port B reads 8 nibbles as one word
  logic [3:0] mem [4096];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) begin
      for (int k = 0; k < 8; k++) ram_dob[4*k +: 4] <= mem[{ram_addrb, 3'(k)}];
    end
  end

  always @(negedge clk) if (ram_enb) enb_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_nib(input logic [3:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) push_nib(w[4*k +: 4]);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rd_valid && n < 20) begin
      cyc();
      n++;
    end
    check_eq(tag, {31'b0, rd_valid}, 32'd1);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  logic [31:0] bp_w [3];
  bit          bp_r [5];
  logic [31:0] exp_q [$];
  logic [31:0] cur;
  int idx, base, stale, nib_idx, sent, recv, maxlvl, ncyc;

  initial begin
    bp_w = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
    bp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_level", {22'b0, level}, 32'd0);
    check_eq("rst_full", {31'b0, full}, 32'd0);
    check_eq("rst_afull", {31'b0, afull}, 32'd0);
    check_eq("rst_empty", {31'b0, empty}, 32'd1);
    check_eq("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    check_eq("rst_ram_ena", {31'b0, ram_ena}, 32'd0);
    check_eq("rst_ram_wea", {31'b0, ram_wea}, 32'd0);
    check_eq("rst_ram_enb", {31'b0, ram_enb}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single word, nibbles 1..8, consumer always ready
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(i + 1);
      #1;
      check_eq("t1_addra", {20'b0, ram_addra}, 32'(i));
      check_eq("t1_wea", {31'b0, ram_wea}, 32'd1);
      cyc();
    end
    wr_valid = 1'b0;
    #1;
    check_eq("t1_level_after_commit", {22'b0, level}, 32'd1);
    check_eq("t1_enb_after_commit", {31'b0, ram_enb}, 32'd1);
    cyc();
    check_eq("t1_valid_e1", {31'b0, rd_valid}, 32'd0);
    cyc();
    check_eq("t1_valid_e2", {31'b0, rd_valid}, 32'd1);
    check_eq("t1_data", rd_data, 32'h87654321);
    cyc();
    check_eq("t1_level_after_pop", {22'b0, level}, 32'd0);
    check_eq("t1_empty_after_pop", {31'b0, empty}, 32'd1);

    // Partial word stays invisible
    rd_ready = 1'b0;
    base = enb_cnt;
    push_nib(4'hA); push_nib(4'hB); push_nib(4'hC); push_nib(4'hD); push_nib(4'hE);
    repeat (4) cyc();
    check_eq("t2_level_partial", {22'b0, level}, 32'd0);
    check_eq("t2_empty_partial", {31'b0, empty}, 32'd1);
    check_eq("t2_no_enb", 32'(enb_cnt - base), 32'd0);
    push_nib(4'hF); push_nib(4'h0); push_nib(4'h1);
    wait_valid("t2_valid");
    check_eq("t2_data", rd_data, 32'h10FEDCBA);
    check_eq("t2_level", {22'b0, level}, 32'd1);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    check_eq("t2_valid_after_pop", {31'b0, rd_valid}, 32'd0);
    check_eq("t2_level_after_pop", {22'b0, level}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1,1
    for (int w = 0; w < 3; w++) push_word(bp_w[w]);
    repeat (4) cyc();
    check_eq("t3_level", {22'b0, level}, 32'd3);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      rd_ready = bp_r[c];
      #1;
      check_eq("t3_valid", {31'b0, rd_valid}, 32'd1);
      check_eq("t3_data", rd_data, bp_w[idx]);
      if (bp_r[c]) idx++;
      cyc();
    end
    rd_ready = 1'b0;
    check_eq("t3_valid_end", {31'b0, rd_valid}, 32'd0);
    check_eq("t3_level_end", {22'b0, level}, 32'd0);

    // Fill to full with the consumer stalled
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      push_nib(4'(i));
      if (i == 8*479 - 1) begin
        check_eq("t4_level_479", {22'b0, level}, 32'd479);
        check_eq("t4_afull_479", {31'b0, afull}, 32'd0);
      end
      if (i == 8*480 - 1) check_eq("t4_afull_480", {31'b0, afull}, 32'd1);
    end
    check_eq("t4_level_full", {22'b0, level}, 32'd512);
    check_eq("t4_full", {31'b0, full}, 32'd1);
    check_eq("t4_empty", {31'b0, empty}, 32'd0);
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    #1;
    check_eq("t4_wr_ready_full", {31'b0, wr_ready}, 32'd0);
    check_eq("t4_ena_full", {31'b0, ram_ena}, 32'd0);
    check_eq("t4_head", rd_data, 32'h76543210);
    cyc();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #1;
    check_eq("t4_wr_ready_after_pop", {31'b0, wr_ready}, 32'd1);
    check_eq("t4_level_after_pop", {22'b0, level}, 32'd511);
    check_eq("t4_full_after_pop", {31'b0, full}, 32'd0);

    // Flush mid-word with two queued words
    do_reset();
    push_word(32'h11112222);
    push_word(32'h33334444);
    push_nib(4'h1); push_nib(4'h2); push_nib(4'h3);
    wait_valid("t5_valid_before");
    check_eq("t5_level_before", {22'b0, level}, 32'd2);
    flush    = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    #1;
    check_eq("t5_wr_ready_flush", {31'b0, wr_ready}, 32'd0);
    check_eq("t5_ena_flush", {31'b0, ram_ena}, 32'd0);
    cyc();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check_eq("t5_empty", {31'b0, empty}, 32'd1);
    check_eq("t5_level", {22'b0, level}, 32'd0);
    check_eq("t5_valid", {31'b0, rd_valid}, 32'd0);
    stale = 0;
    repeat (5) begin
      cyc();
      if (rd_valid) stale++;
    end
    check_eq("t5_no_stale", 32'(stale), 32'd0);
    rd_ready = 1'b0;
    push_word(32'h5A5A1234);
    wait_valid("t5_valid_new");
    check_eq("t5_data_new", rd_data, 32'h5A5A1234);

    // Asynchronous reset mid-word with two queued words
    push_word(32'hAAAA0001);
    push_nib(4'h7); push_nib(4'h8);
    rst_n = 1'b0;
    #1;
    check_eq("t6_empty", {31'b0, empty}, 32'd1);
    check_eq("t6_level", {22'b0, level}, 32'd0);
    check_eq("t6_valid", {31'b0, rd_valid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push_word(32'hC0FFEE01);
    wait_valid("t6_valid_new");
    check_eq("t6_data_new", rd_data, 32'hC0FFEE01);
    check_eq("t6_level_new", {22'b0, level}, 32'd1);

    // Long random stream across the 511 -> 0 word wrap
    do_reset();
    nib_idx = 0; sent = 0; recv = 0; maxlvl = 0; ncyc = 0; cur = '0;
    while (recv < 1100 && ncyc < 40000) begin
      wr_valid = (sent < 8800) && ($urandom_range(0, 3) != 0);
      wr_data  = 4'($urandom_range(0, 15));
      rd_ready = ($urandom_range(0, 3) == 0);
      #1;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (wr_valid && wr_ready) begin
        cur[4*nib_idx +: 4] = wr_data;
        nib_idx++;
        sent++;
        if (nib_idx == 8) begin
          exp_q.push_back(cur);
          nib_idx = 0;
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) check_eq("t7_extra_word", 32'd1, 32'd0);
        else check_eq("t7_data", rd_data, exp_q.pop_front());
        recv++;
      end
      cyc();
      ncyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check_eq("t7_received", 32'(recv), 32'd1100);
    check_eq("t7_max_level_ok", {31'b0, (maxlvl <= 512)}, 32'd1);
    check_eq("t7_level_end", {22'b0, level}, 32'd0);
    check_eq("t7_empty_end", {31'b0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
